// File: rtl/me_scan_ctrl.sv
// Full-search motion-estimation scheduler: loads the current macroblock into the PE matrix,
// streams the search window column by column, and tags complete SAD candidates.
module me_scan_ctrl #(
    parameter int unsigned MACRO_DIM  = 16,
    parameter int unsigned SEARCH_DIM = 48,
    localparam int unsigned AW = $clog2(SEARCH_DIM),
    localparam int unsigned CW = $clog2(MACRO_DIM)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          cur_rd_en,
    output logic [CW-1:0] cur_row,
    output logic          spr_rd_en,
    output logic [AW-1:0] spr_row,
    output logic [AW-1:0] spr_col,
    output logic          en_cpr,
    output logic          en_spr,
    output logic          sel,
    output logic          cand_valid,
    output logic [AW-1:0] cand_x,
    output logic [AW-1:0] cand_y
);

    localparam int unsigned NPOS = SEARCH_DIM - MACRO_DIM + 1;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_CUR,
        SCAN,
        DRAIN
    } state_t;

    state_t        state, state_next;
    logic [CW-1:0] cur_row_next;
    logic [AW-1:0] spr_row_next;
    logic [AW-1:0] spr_col_next;
    logic          drain_cnt, drain_next;
    logic          done_next;

    logic          tag_c;
    logic [AW-1:0] tag_y_c;
    logic          tag_v1;
    logic [AW-1:0] tag_x1;
    logic [AW-1:0] tag_y1;

    // Next-state and counter sequencing; the row/column outputs are the counters themselves.
    always_comb begin
        state_next   = state;
        cur_row_next = cur_row;
        spr_row_next = spr_row;
        spr_col_next = spr_col;
        drain_next   = drain_cnt;
        done_next    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = LOAD_CUR;
            end
            LOAD_CUR: begin
                if (cur_row == CW'(MACRO_DIM - 1)) begin
                    cur_row_next = '0;
                    state_next   = SCAN;
                end else begin
                    cur_row_next = cur_row + CW'(1);
                end
            end
            SCAN: begin
                if (spr_row == AW'(SEARCH_DIM - 1)) begin
                    spr_row_next = '0;
                    if (spr_col == AW'(NPOS - 1)) begin
                        spr_col_next = '0;
                        state_next   = DRAIN;
                    end else begin
                        spr_col_next = spr_col + AW'(1);
                    end
                end else begin
                    spr_row_next = spr_row + AW'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    drain_next = 1'b0;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    drain_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A read of row r >= MACRO_DIM-1 completes candidate (col, r-MACRO_DIM+1).
    always_comb begin
        tag_c   = spr_rd_en && (spr_row >= AW'(MACRO_DIM - 1));
        tag_y_c = spr_row - AW'(MACRO_DIM - 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cur_row    <= '0;
            spr_row    <= '0;
            spr_col    <= '0;
            drain_cnt  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cur_rd_en  <= 1'b0;
            spr_rd_en  <= 1'b0;
            sel        <= 1'b0;
            en_cpr     <= 1'b0;
            en_spr     <= 1'b0;
            tag_v1     <= 1'b0;
            tag_x1     <= '0;
            tag_y1     <= '0;
            cand_valid <= 1'b0;
            cand_x     <= '0;
            cand_y     <= '0;
        end else begin
            state      <= state_next;
            cur_row    <= cur_row_next;
            spr_row    <= spr_row_next;
            spr_col    <= spr_col_next;
            drain_cnt  <= drain_next;
            busy       <= (state_next != IDLE);
            done       <= done_next;
            cur_rd_en  <= (state_next == LOAD_CUR);
            spr_rd_en  <= (state_next == SCAN);
            sel        <= (state_next == SCAN) || (state_next == DRAIN);
            // Shift enables follow the buffer's one-cycle read latency.
            en_cpr     <= cur_rd_en;
            en_spr     <= spr_rd_en;
            tag_v1     <= tag_c;
            tag_x1     <= tag_c ? spr_col : '0;
            tag_y1     <= tag_c ? tag_y_c : '0;
            cand_valid <= tag_v1;
            cand_x     <= tag_x1;
            cand_y     <= tag_y1;
        end
    end

endmodule

// File: tb/tb_me_scan_ctrl.sv
// Directed bench for me_scan_ctrl: cycle-exact schedule model, candidate order scoreboard,
// start-while-busy, back-to-back and mid-search reset.
module tb_me_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       cur_rd_en;
    logic [3:0] cur_row;
    logic       spr_rd_en;
    logic [5:0] spr_row;
    logic [5:0] spr_col;
    logic       en_cpr;
    logic       en_spr;
    logic       sel;
    logic       cand_valid;
    logic [5:0] cand_x;
    logic [5:0] cand_y;

    int n_tests = 0;
    int n_fail  = 0;

    me_scan_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .cur_rd_en  (cur_rd_en),
        .cur_row    (cur_row),
        .spr_rd_en  (spr_rd_en),
        .spr_row    (spr_row),
        .spr_col    (spr_col),
        .en_cpr     (en_cpr),
        .en_spr     (en_spr),
        .sel        (sel),
        .cand_valid (cand_valid),
        .cand_x     (cand_x),
        .cand_y     (cand_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({busy, done, cur_rd_en, cur_row, en_cpr, spr_rd_en, spr_row, spr_col,
                    en_spr, sel, cand_valid, cand_x, cand_y});
    endfunction

    // Caller sets start before the edge T; interval n is the cycle after edge T+n-1.
    task automatic run_search(input string name, input bit hold, input int p1, input int p2);
        int ncand, ex, ey, first_n, last_n, ndone, s, m, sm;
        bit e_busy, e_done, e_cur, e_cpr, e_spr, e_en_spr, e_cv;
        int e_row, e_srow, e_scol;
        ncand = 0; ex = 0; ey = 0; first_n = -1; last_n = -1; ndone = 0;
        @(posedge clk);
        for (int n = 1; n <= 1603; n++) begin
            @(negedge clk);
            e_busy   = (n <= 1602);
            e_done   = (n == 1603);
            e_cur    = (n >= 1) && (n <= 16);
            e_row    = e_cur ? n - 1 : 0;
            e_cpr    = (n >= 2) && (n <= 17);
            e_spr    = (n >= 17) && (n <= 1600);
            s        = n - 17;
            e_scol   = e_spr ? s / 48 : 0;
            e_srow   = e_spr ? s % 48 : 0;
            e_en_spr = (n >= 18) && (n <= 1601);
            m        = n - 2;
            sm       = m - 17;
            e_cv     = (m >= 17) && (m <= 1600) && ((sm % 48) >= 15);
            check({name, " ctrl"},
                  64'({busy, done, cur_rd_en, cur_row, en_cpr, spr_rd_en, spr_row, spr_col,
                       en_spr, cand_valid}),
                  64'({e_busy, e_done, e_cur, 4'(e_row), e_cpr, e_spr, 6'(e_srow), 6'(e_scol),
                       e_en_spr, e_cv}));
            if (n <= 1600) check({name, " sel"}, 64'(sel), 64'(n >= 17));
            if (cand_valid === 1'b1) begin
                check({name, " cand_xy"}, 64'({cand_x, cand_y}), 64'({6'(ex), 6'(ey)}));
                ey++;
                if (ey == 33) begin
                    ey = 0;
                    ex++;
                end
                ncand++;
                if (first_n < 0) first_n = n;
                last_n = n;
            end
            if (done === 1'b1) ndone++;
            if (n == 1 && !hold) start = 1'b0;
            if (n == p1 || n == p2) start = 1'b1;
            if ((n == p1 + 1 || n == p2 + 1) && !hold) start = 1'b0;
        end
        check({name, " cand_count"}, 64'(ncand), 64'd1089);
        check({name, " first_cand_cycle"}, 64'(first_n), 64'd34);
        check({name, " last_cand_cycle"}, 64'(last_n), 64'd1602);
        check({name, " done_count"}, 64'(ndone), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_state", all_outs(), 64'd0);
        rst_n = 1'b1;

        // Idle with start low: nothing moves.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_quiet", all_outs(), 64'd0);
        end

        start = 1'b1;
        run_search("single", 1'b0, 0, 0);

        repeat (3) @(negedge clk);
        start = 1'b1;
        run_search("start_while_busy", 1'b0, 100, 900);

        // Held start: second search accepted in the done cycle.
        repeat (2) @(negedge clk);
        start = 1'b1;
        run_search("b2b_first", 1'b1, 0, 0);
        run_search("b2b_second", 1'b0, 0, 0);

        // Mid-search asynchronous reset.
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 499; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
        end
        check("pre_reset_progress", 64'({busy, spr_rd_en, spr_col, spr_row}),
              64'({1'b1, 1'b1, 6'd10, 6'd2}));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_reset_clear", all_outs(), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("in_reset", all_outs(), 64'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_reset_idle", all_outs(), 64'd0);
        end
        start = 1'b1;
        run_search("after_reset", 1'b0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
